// File: rtl/rgb_byte_assembler_pkg.sv
// -----------------------------------------------------------------------------
// rgb_byte_assembler_pkg
//   Shared definitions for the RGB byte assembler slice.
//   - DEFAULT_BYTE_W   : width of one beat on the narrow chip input bus
//   - MAX_PIXEL_BITS   : packed RGB888 pixel width (three beats)
//   - PIXEL_WIDTH_OUT  : pixel width as seen by the grayscale core input
//   - beat_idx_t       : which slot of the pixel an incoming beat fills
// -----------------------------------------------------------------------------
package rgb_byte_assembler_pkg;

  localparam int DEFAULT_BYTE_W  = 8;
  localparam int MAX_PIXEL_BITS  = 3 * DEFAULT_BYTE_W;
  localparam int PIXEL_WIDTH_OUT = MAX_PIXEL_BITS;

  // Position of a beat inside the pixel it belongs to, in arrival order.
  typedef enum logic [1:0] {
    BEAT0 = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } beat_idx_t;

endpackage

// File: rtl/rgb_stall_timer.sv
// -----------------------------------------------------------------------------
// rgb_stall_timer
//   Counts idle cycles while a pixel is partially collected and flags when the
//   allowed number of idle cycles has been used up.
// Ports
//   clk_i       in   rising-edge clock
//   reset_i     in   asynchronous active-high reset
//   clear_i     in   force the count back to zero (wins over count_en_i)
//   count_en_i  in   advance the count by one this cycle
//   expired_o   out  count has reached TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module rgb_stall_timer
  import rgb_byte_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  // Next count: clear has priority; the count holds once it reaches the limit
  // so it can never wrap back to a small value while the owner waits.
  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (count_en_i && (timer_q != TW'(TIMEOUT_CYCLES))) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expired_o = (timer_q == TW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/rgb_byte_assembler.sv
// -----------------------------------------------------------------------------
// rgb_byte_assembler
//   Producer end of the 24-bit RGB pixel interface feeding the grayscale core.
//   Collects three beats from the narrow input bus, packs them into one RGB888
//   word and pulses px_rdy_o for one cycle per completed pixel. Realigns on
//   start-of-frame, drops a partial pixel when the bus stalls too long, and
//   counts pixels per frame.
// Ports
//   clk_i         in   rising-edge clock
//   reset_i       in   asynchronous active-high reset
//   byte_valid_i  in   byte_i carries a beat this cycle (always accepted)
//   byte_i        in   input beat
//   sof_i         in   start of frame: realign to beat 0, clear pixel count
//   px_rdy_o      out  one-cycle pulse: px_rgb_o holds a new pixel
//   px_rgb_o      out  packed pixel, R in the top byte, B in the bottom byte
//   err_o         out  one-cycle pulse: partial pixel discarded by the stall timer
//   pixel_cnt_o   out  pixels completed since the last sof_i (saturating)
// -----------------------------------------------------------------------------
module rgb_byte_assembler
  import rgb_byte_assembler_pkg::*;
#(
  parameter int BYTE_W         = DEFAULT_BYTE_W,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit RED_FIRST      = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  byte_valid_i,
  input  logic [BYTE_W-1:0]     byte_i,
  input  logic                  sof_i,
  output logic                  px_rdy_o,
  output logic [3*BYTE_W-1:0]   px_rgb_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      pixel_cnt_o
);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [BYTE_W-1:0]     beat0_q;
  logic [BYTE_W-1:0]     beat0_d;
  logic [BYTE_W-1:0]     beat1_q;
  logic [BYTE_W-1:0]     beat1_d;
  logic [3*BYTE_W-1:0]   pxRgb_q;
  logic [3*BYTE_W-1:0]   pxRgb_d;
  logic                  pxRdy_q;
  logic                  pxRdy_d;
  logic                  err_q;
  logic                  err_d;
  logic [CNT_W-1:0]      pixelCnt_q;
  logic [CNT_W-1:0]      pixelCnt_d;

  beat_idx_t             curBeat;
  logic                  timerExpired;
  logic                  timerClear;
  logic                  timerCountEn;
  logic                  stallAbort;
  logic                  pixelDone;

  // Slot that a beat arriving this cycle would fill. Start-of-frame always
  // realigns, so a beat coupled with sof_i is the first beat of a new pixel.
  always_comb begin
    curBeat = BEAT0;
    if (!sof_i) begin
      case (state_q)
        WAIT_B1: curBeat = BEAT1;
        WAIT_B2: curBeat = BEAT2;
        default: curBeat = BEAT0;
      endcase
    end
  end

  // A stall only aborts the pixel when nothing of higher priority happens in
  // the same cycle: a beat on the expiry cycle is taken normally, and sof_i
  // discards the partial pixel silently.
  assign stallAbort   = timerExpired && !byte_valid_i && !sof_i;
  assign pixelDone    = byte_valid_i && (curBeat == BEAT2);

  // The timer only measures stalls inside a pixel; in WAIT_B0 it is held at 0.
  assign timerClear   = sof_i || byte_valid_i || stallAbort || (state_q == WAIT_B0);
  assign timerCountEn = (state_q != WAIT_B0) && !byte_valid_i;

  rgb_stall_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) uStallTimer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (timerClear),
    .count_en_i (timerCountEn),
    .expired_o  (timerExpired)
  );

  // Beat sequencer: every valid beat advances one slot; sof_i and a stall
  // abort both send the sequencer back to waiting for the first beat.
  always_comb begin
    state_d = state_q;
    if (byte_valid_i) begin
      case (curBeat)
        BEAT0:   state_d = WAIT_B1;
        BEAT1:   state_d = WAIT_B2;
        BEAT2:   state_d = WAIT_B0;
        default: state_d = WAIT_B0;
      endcase
    end else if (sof_i || stallAbort) begin
      state_d = WAIT_B0;
    end
  end

  // Datapath: the first two beats are parked in private registers so the
  // output word only ever changes to a complete pixel. The third beat is
  // packed straight into the output register together with the parked ones.
  always_comb begin
    beat0_d    = beat0_q;
    beat1_d    = beat1_q;
    pxRgb_d    = pxRgb_q;
    pxRdy_d    = pixelDone;
    err_d      = stallAbort;
    pixelCnt_d = pixelCnt_q;

    if (byte_valid_i) begin
      case (curBeat)
        BEAT0:   beat0_d = byte_i;
        BEAT1:   beat1_d = byte_i;
        BEAT2: begin
          if (RED_FIRST) begin
            pxRgb_d = {beat0_q, beat1_q, byte_i};
          end else begin
            pxRgb_d = {byte_i, beat1_q, beat0_q};
          end
        end
        default: beat0_d = beat0_q;
      endcase
    end

    if (sof_i) begin
      pixelCnt_d = '0;
    end else if (pixelDone && (pixelCnt_q != {CNT_W{1'b1}})) begin
      pixelCnt_d = pixelCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= WAIT_B0;
      beat0_q    <= '0;
      beat1_q    <= '0;
      pxRgb_q    <= '0;
      pxRdy_q    <= 1'b0;
      err_q      <= 1'b0;
      pixelCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat0_q    <= beat0_d;
      beat1_q    <= beat1_d;
      pxRgb_q    <= pxRgb_d;
      pxRdy_q    <= pxRdy_d;
      err_q      <= err_d;
      pixelCnt_q <= pixelCnt_d;
    end
  end

  assign px_rdy_o    = pxRdy_q;
  assign px_rgb_o    = pxRgb_q;
  assign err_o       = err_q;
  assign pixel_cnt_o = pixelCnt_q;

endmodule
